// File: rtl/codec_cfg_pkg.sv
// rtl/codec_cfg_pkg.sv - shared types and WM8731 configuration table for codec_cfg_sequencer
package codec_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_GAP,
        ST_SETTLE,
        ST_DONE,
        ST_ERROR
    } state_t;

    localparam int         TABLE_DEPTH = 11;
    localparam logic [3:0] LAST_INDEX  = 4'(TABLE_DEPTH - 1);

    // WM8731 register addresses
    localparam logic [6:0] WM_R0_LLINE_IN   = 7'h00;
    localparam logic [6:0] WM_R1_RLINE_IN   = 7'h01;
    localparam logic [6:0] WM_R2_LHP_OUT    = 7'h02;
    localparam logic [6:0] WM_R3_RHP_OUT    = 7'h03;
    localparam logic [6:0] WM_R4_ANA_PATH   = 7'h04;
    localparam logic [6:0] WM_R5_DIG_PATH   = 7'h05;
    localparam logic [6:0] WM_R6_POWER_DOWN = 7'h06;
    localparam logic [6:0] WM_R7_DIG_IF     = 7'h07;
    localparam logic [6:0] WM_R8_SAMPLING   = 7'h08;
    localparam logic [6:0] WM_R9_ACTIVE     = 7'h09;
    localparam logic [6:0] WM_R15_RESET     = 7'h0F;

    // Values written to each register, in table order
    localparam logic [8:0] VAL_RESET      = 9'h000;
    localparam logic [8:0] VAL_LLINE_IN   = 9'h017;
    localparam logic [8:0] VAL_RLINE_IN   = 9'h017;
    localparam logic [8:0] VAL_LHP_OUT    = 9'h079;
    localparam logic [8:0] VAL_RHP_OUT    = 9'h079;
    localparam logic [8:0] VAL_ANA_PATH   = 9'h012;
    localparam logic [8:0] VAL_DIG_PATH   = 9'h000;
    localparam logic [8:0] VAL_POWER_DOWN = 9'h000;
    localparam logic [8:0] VAL_DIG_IF     = 9'h042;
    localparam logic [8:0] VAL_SAMPLING   = 9'h000;
    localparam logic [8:0] VAL_ACTIVE     = 9'h001;

    // Packs a register address and its 9-bit value into the 16-bit control word
    function automatic logic [15:0] cfg_word(input logic [6:0] reg_addr, input logic [8:0] reg_val);
        return {reg_addr, reg_val};
    endfunction

endpackage

// File: rtl/codec_cfg_rom.sv
// rtl/codec_cfg_rom.sv - combinational index-to-{reg,val} lookup of the codec configuration table
module codec_cfg_rom
    import codec_cfg_pkg::*;
(
    input  logic [3:0]  index_i,
    output logic [15:0] word_o
);

    // Table lookup; indices beyond the last entry read as zero
    always_comb begin
        word_o = 16'h0000;
        case (index_i)
            4'd0:    word_o = cfg_word(WM_R15_RESET,     VAL_RESET);
            4'd1:    word_o = cfg_word(WM_R0_LLINE_IN,   VAL_LLINE_IN);
            4'd2:    word_o = cfg_word(WM_R1_RLINE_IN,   VAL_RLINE_IN);
            4'd3:    word_o = cfg_word(WM_R2_LHP_OUT,    VAL_LHP_OUT);
            4'd4:    word_o = cfg_word(WM_R3_RHP_OUT,    VAL_RHP_OUT);
            4'd5:    word_o = cfg_word(WM_R4_ANA_PATH,   VAL_ANA_PATH);
            4'd6:    word_o = cfg_word(WM_R5_DIG_PATH,   VAL_DIG_PATH);
            4'd7:    word_o = cfg_word(WM_R6_POWER_DOWN, VAL_POWER_DOWN);
            4'd8:    word_o = cfg_word(WM_R7_DIG_IF,     VAL_DIG_IF);
            4'd9:    word_o = cfg_word(WM_R8_SAMPLING,   VAL_SAMPLING);
            4'd10:   word_o = cfg_word(WM_R9_ACTIVE,     VAL_ACTIVE);
            default: word_o = 16'h0000;
        endcase
    end

endmodule

// File: rtl/codec_cfg_sequencer.sv
// rtl/codec_cfg_sequencer.sv - WM8731 I2C configuration sequencer; CODEC_CFG_TIMEOUT_EN adds a WAIT watchdog
module codec_cfg_sequencer #(
    parameter logic [6:0] I2C_DEV_ADDR   = 7'h1A,
    parameter int         RETRY_MAX      = 3,
    parameter int         SETTLE_CYCLES  = 50000,
    parameter int         TIMEOUT_CYCLES = 500000
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        start,
    output logic        i2c_req,
    output logic [23:0] i2c_data,
    input  logic        i2c_done,
    input  logic        i2c_nack,
    output logic        cfg_done,
    output logic        cfg_error,
    output logic [3:0]  cfg_index
);

    import codec_cfg_pkg::*;

    // Counters are sized from these values; settings below 1 have no meaningful behaviour
    if (SETTLE_CYCLES < 1 || RETRY_MAX < 1 || TIMEOUT_CYCLES < 1) begin : g_param_range_invalid
    end

    localparam int                    SETTLE_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SETTLE_W-1:0]   SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam int                    RETRY_W     = $clog2(RETRY_MAX + 1);
    localparam logic [RETRY_W-1:0]    RETRY_LIMIT = RETRY_W'(RETRY_MAX);

    state_t              state_q, state_d;
    logic [3:0]          index_q, index_d;
    logic [RETRY_W-1:0]  retry_q, retry_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [23:0]         data_q, data_d;
    logic [RETRY_W-1:0]  retry_inc;
    logic [15:0]         rom_word;
    logic                xfer_ok;
    logic                xfer_fail;

`ifdef CODEC_CFG_TIMEOUT_EN
    localparam int                WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    logic [WD_W-1:0]              wd_q, wd_d;
`endif

    codec_cfg_rom u_rom (
        .index_i (index_q),
        .word_o  (rom_word)
    );

    assign retry_inc = retry_q + 1'b1;

    // State and datapath registers; reset returns everything to IDLE with counters cleared
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            index_q  <= 4'd0;
            retry_q  <= '0;
            settle_q <= '0;
            data_q   <= 24'd0;
`ifdef CODEC_CFG_TIMEOUT_EN
            wd_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            index_q  <= index_d;
            retry_q  <= retry_d;
            settle_q <= settle_d;
            data_q   <= data_d;
`ifdef CODEC_CFG_TIMEOUT_EN
            wd_q     <= wd_d;
`endif
        end
    end

    // Next-state and counter updates; i2c_done is looked at only while waiting on the master
    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        retry_d   = retry_q;
        settle_d  = settle_q;
        data_d    = data_q;
        xfer_ok   = 1'b0;
        xfer_fail = 1'b0;
`ifdef CODEC_CFG_TIMEOUT_EN
        wd_d      = wd_q;
`endif
        case (state_q)
            ST_IDLE: begin
                index_d = 4'd0;
                retry_d = '0;
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                data_d  = {I2C_DEV_ADDR, 1'b0, rom_word};
`ifdef CODEC_CFG_TIMEOUT_EN
                wd_d    = '0;
`endif
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (i2c_done) begin
                    xfer_ok   = !i2c_nack;
                    xfer_fail = i2c_nack;
                end
`ifdef CODEC_CFG_TIMEOUT_EN
                else if (wd_q == WD_LAST) begin
                    xfer_fail = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
                if (xfer_ok) begin
                    retry_d = '0;
                    if (index_q == 4'd0) begin
                        settle_d = '0;
                        state_d  = ST_SETTLE;
                    end else if (index_q == LAST_INDEX) begin
                        state_d = ST_DONE;
                    end else begin
                        index_d = index_q + 4'd1;
                        state_d = ST_GAP;
                    end
                end else if (xfer_fail) begin
                    retry_d = retry_inc;
                    state_d = (retry_inc < RETRY_LIMIT) ? ST_GAP : ST_ERROR;
                end
            end
            ST_GAP: begin
                state_d = ST_ISSUE;
            end
            ST_SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    index_d = 4'd1;
                    state_d = ST_ISSUE;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            ST_DONE, ST_ERROR: begin
                if (start) begin
                    index_d = 4'd0;
                    retry_d = '0;
                    state_d = ST_ISSUE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from the current state and held registers
    always_comb begin
        i2c_req   = (state_q == ST_WAIT);
        cfg_done  = (state_q == ST_DONE);
        cfg_error = (state_q == ST_ERROR);
        i2c_data  = data_q;
        cfg_index = index_q;
    end

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// tb/tb_codec_cfg_sequencer.sv - directed self-checking bench for codec_cfg_sequencer
module tb_codec_cfg_sequencer;

    localparam int SETTLE     = 40;
    localparam int TIMEOUT    = 100;
    localparam int WAIT_BOUND = 400;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        i2c_done;
    logic        i2c_nack;
    logic        i2c_req;
    logic [23:0] i2c_data;
    logic        cfg_done;
    logic        cfg_error;
    logic [3:0]  cfg_index;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int stable_viol = 0;

    bit          req_prev = 1'b0;
    logic [23:0] data_prev = 24'd0;
    logic [23:0] rise_data[$];
    int          rise_cyc[$];
    logic [3:0]  rise_idx[$];

    // {addr 0x1A, W, reg[6:0], val[8:0]} worked by hand for every table entry
    logic [23:0] exp_word [0:10] = '{
        24'h341E00, 24'h340017, 24'h340217, 24'h340479, 24'h340679, 24'h340812,
        24'h340A00, 24'h340C00, 24'h340E42, 24'h341000, 24'h341201
    };

    codec_cfg_sequencer #(
        .I2C_DEV_ADDR   (7'h1A),
        .RETRY_MAX      (3),
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .CLOCK_50  (clk),
        .reset     (reset),
        .start     (start),
        .i2c_req   (i2c_req),
        .i2c_data  (i2c_data),
        .i2c_done  (i2c_done),
        .i2c_nack  (i2c_nack),
        .cfg_done  (cfg_done),
        .cfg_error (cfg_error),
        .cfg_index (cfg_index)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every request rising edge and watch i2c_data while a request is held
    always @(negedge clk) begin
        if (i2c_req === 1'b1 && !req_prev) begin
            rise_data.push_back(i2c_data);
            rise_cyc.push_back(cyc);
            rise_idx.push_back(cfg_index);
        end
        if (i2c_req === 1'b1 && req_prev && i2c_data !== data_prev) stable_viol++;
        req_prev  = (i2c_req === 1'b1);
        data_prev = i2c_data;
    end

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        start    = 1'b0;
        i2c_done = 1'b0;
        i2c_nack = 1'b0;
        repeat (2) @(negedge clk);
        rise_data.delete();
        rise_cyc.delete();
        rise_idx.delete();
        reset = 1'b0;
    endtask

    // I2C master stand-in: waits for a request, answers on its second WAIT cycle
    task automatic respond(input logic nack_v, output bit ok);
        int n;
        n = 0;
        while (i2c_req !== 1'b1 && n < WAIT_BOUND) begin
            @(negedge clk);
            n++;
        end
        ok = (i2c_req === 1'b1);
        if (ok) begin
            @(negedge clk);
            i2c_done = 1'b1;
            i2c_nack = nack_v;
            @(negedge clk);
            i2c_done = 1'b0;
            i2c_nack = 1'b0;
        end
    endtask

    task automatic wait_req(output bit ok);
        int n;
        n = 0;
        while (i2c_req !== 1'b1 && n < WAIT_BOUND) begin
            @(negedge clk);
            n++;
        end
        ok = (i2c_req === 1'b1);
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        start    = 1'b0;
        i2c_done = 1'b0;
        i2c_nack = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (i2c_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", i2c_req); end
        checks++; if (i2c_data !== 24'd0) begin errors++; $display("FAIL rst_data: got %h expected 000000", i2c_data); end
        checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", cfg_done); end
        checks++; if (cfg_error !== 1'b0) begin errors++; $display("FAIL rst_error: got %b expected 0", cfg_error); end
        checks++; if (cfg_index !== 4'd0) begin errors++; $display("FAIL rst_index: got %0d expected 0", cfg_index); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (i2c_req !== 1'b0) begin errors++; $display("FAIL issue_no_req: got %b expected 0", i2c_req); end
        @(negedge clk);
        checks++; if (i2c_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b expected 1", i2c_req); end
        checks++; if (i2c_data !== 24'h341E00) begin errors++; $display("FAIL first_data: got %h expected 341e00", i2c_data); end
    endtask

    task automatic test_full_sequence();
        bit ok;
        bit all_ok;
        all_ok = 1'b1;
        do_reset();
        for (int t = 0; t < 11; t++) begin
            respond(1'b0, ok);
            all_ok &= ok;
        end
        checks++; if (!all_ok) begin errors++; $display("FAIL full_handshake: got timeout expected 11 requests"); end
        checks++; if (rise_data.size() != 11) begin errors++; $display("FAIL full_count: got %0d expected 11", rise_data.size()); end
        for (int i = 0; i < 11 && i < rise_data.size(); i++) begin
            checks++;
            if (rise_data[i] !== exp_word[i]) begin
                errors++; $display("FAIL full_data[%0d]: got %h expected %h", i, rise_data[i], exp_word[i]);
            end
        end
        if (rise_cyc.size() >= 3) begin
            // 2 WAIT + SETTLE + 1 ISSUE between entry 0 and entry 1; 2 WAIT + GAP + ISSUE otherwise
            checks++; if (rise_cyc[1] - rise_cyc[0] != SETTLE + 3) begin errors++; $display("FAIL settle_gap: got %0d expected %0d", rise_cyc[1] - rise_cyc[0], SETTLE + 3); end
            checks++; if (rise_cyc[2] - rise_cyc[1] != 4) begin errors++; $display("FAIL entry_gap: got %0d expected 4", rise_cyc[2] - rise_cyc[1]); end
        end
        checks++; if (cfg_done !== 1'b1) begin errors++; $display("FAIL full_done: got %b expected 1", cfg_done); end
        checks++; if (cfg_error !== 1'b0) begin errors++; $display("FAIL full_error: got %b expected 0", cfg_error); end
        checks++; if (cfg_index !== 4'd10) begin errors++; $display("FAIL full_index: got %0d expected 10", cfg_index); end
        checks++; if (i2c_req !== 1'b0) begin errors++; $display("FAIL full_req: got %b expected 0", i2c_req); end
    endtask

    task automatic test_nack_retry();
        bit ok;
        bit all_ok;
        all_ok = 1'b1;
        do_reset();
        for (int t = 0; t < 13; t++) begin
            respond((t == 5 || t == 6), ok);
            all_ok &= ok;
        end
        checks++; if (!all_ok) begin errors++; $display("FAIL retry_handshake: got timeout expected 13 requests"); end
        checks++; if (rise_data.size() != 13) begin errors++; $display("FAIL retry_count: got %0d expected 13", rise_data.size()); end
        if (rise_data.size() == 13) begin
            for (int i = 5; i < 8; i++) begin
                checks++; if (rise_data[i] !== exp_word[5]) begin errors++; $display("FAIL retry_data[%0d]: got %h expected %h", i, rise_data[i], exp_word[5]); end
                checks++; if (rise_idx[i] !== 4'd5) begin errors++; $display("FAIL retry_idx[%0d]: got %0d expected 5", i, rise_idx[i]); end
            end
            checks++; if (rise_cyc[6] - rise_cyc[5] != 4) begin errors++; $display("FAIL retry_gap: got %0d expected 4", rise_cyc[6] - rise_cyc[5]); end
            checks++; if (rise_data[8] !== exp_word[6]) begin errors++; $display("FAIL retry_next: got %h expected %h", rise_data[8], exp_word[6]); end
            checks++; if (rise_data[12] !== exp_word[10]) begin errors++; $display("FAIL retry_last: got %h expected %h", rise_data[12], exp_word[10]); end
        end
        checks++; if (cfg_done !== 1'b1) begin errors++; $display("FAIL retry_done: got %b expected 1", cfg_done); end
    endtask

    task automatic test_nack_error();
        bit ok;
        bit all_ok;
        all_ok = 1'b1;
        do_reset();
        for (int t = 0; t < 6; t++) begin
            respond((t >= 3), ok);
            all_ok &= ok;
        end
        checks++; if (!all_ok) begin errors++; $display("FAIL err_handshake: got timeout expected 6 requests"); end
        checks++; if (rise_data.size() != 6) begin errors++; $display("FAIL err_count: got %0d expected 6", rise_data.size()); end
        checks++; if (cfg_error !== 1'b1) begin errors++; $display("FAIL err_flag: got %b expected 1", cfg_error); end
        checks++; if (cfg_index !== 4'd3) begin errors++; $display("FAIL err_index: got %0d expected 3", cfg_index); end
        checks++; if (i2c_req !== 1'b0) begin errors++; $display("FAIL err_req: got %b expected 0", i2c_req); end
        checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL err_done: got %b expected 0", cfg_done); end
        i2c_done = 1'b1;
        @(negedge clk);
        i2c_done = 1'b0;
        checks++; if (cfg_error !== 1'b1 || cfg_index !== 4'd3) begin errors++; $display("FAIL err_stray_done: got error=%b index=%0d expected error=1 index=3", cfg_error, cfg_index); end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (cfg_error !== 1'b0) begin errors++; $display("FAIL restart_error: got %b expected 0", cfg_error); end
        checks++; if (cfg_index !== 4'd0) begin errors++; $display("FAIL restart_index: got %0d expected 0", cfg_index); end
        @(negedge clk);
        checks++; if (i2c_req !== 1'b1) begin errors++; $display("FAIL restart_req: got %b expected 1", i2c_req); end
        checks++; if (i2c_data !== 24'h341E00) begin errors++; $display("FAIL restart_data: got %h expected 341e00", i2c_data); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit all_ok;
        all_ok = 1'b1;
        do_reset();
        for (int t = 0; t < 7; t++) begin
            respond(1'b0, ok);
            all_ok &= ok;
        end
        wait_req(ok);
        all_ok &= ok;
        checks++; if (!all_ok) begin errors++; $display("FAIL mid_handshake: got timeout expected entry 7 request"); end
        checks++; if (cfg_index !== 4'd7) begin errors++; $display("FAIL mid_index: got %0d expected 7", cfg_index); end
        reset = 1'b1;
        #1;
        checks++; if (i2c_req !== 1'b0) begin errors++; $display("FAIL mid_req: got %b expected 0", i2c_req); end
        checks++; if (i2c_data !== 24'd0) begin errors++; $display("FAIL mid_data: got %h expected 000000", i2c_data); end
        checks++; if (cfg_index !== 4'd0) begin errors++; $display("FAIL mid_rst_index: got %0d expected 0", cfg_index); end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (i2c_req !== 1'b1 || i2c_data !== 24'h341E00 || cfg_index !== 4'd0) begin
            errors++; $display("FAIL mid_reissue: got req=%b data=%h index=%0d expected req=1 data=341e00 index=0", i2c_req, i2c_data, cfg_index);
        end
    endtask

    task automatic test_ignored();
        bit ok;
        bit all_ok;
        all_ok = 1'b1;
        do_reset();
        respond(1'b0, ok);
        all_ok &= ok;
        @(negedge clk);
        i2c_done = 1'b1;
        @(negedge clk);
        i2c_done = 1'b0;
        checks++; if (i2c_req !== 1'b0 || cfg_index !== 4'd0) begin errors++; $display("FAIL settle_stray: got req=%b index=%0d expected req=0 index=0", i2c_req, cfg_index); end
        wait_req(ok);
        all_ok &= ok;
        checks++; if (cfg_index !== 4'd1 || i2c_data !== exp_word[1]) begin errors++; $display("FAIL settle_exit: got index=%0d data=%h expected index=1 data=%h", cfg_index, i2c_data, exp_word[1]); end
        if (rise_cyc.size() >= 2) begin
            checks++; if (rise_cyc[1] - rise_cyc[0] != SETTLE + 3) begin errors++; $display("FAIL settle_len: got %0d expected %0d", rise_cyc[1] - rise_cyc[0], SETTLE + 3); end
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (i2c_req !== 1'b1 || cfg_index !== 4'd1 || i2c_data !== exp_word[1]) begin
            errors++; $display("FAIL wait_start: got req=%b index=%0d data=%h expected req=1 index=1 data=%h", i2c_req, cfg_index, i2c_data, exp_word[1]);
        end
        respond(1'b0, ok);
        all_ok &= ok;
        wait_req(ok);
        all_ok &= ok;
        checks++; if (!all_ok) begin errors++; $display("FAIL ign_handshake: got timeout expected requests"); end
        checks++; if (cfg_index !== 4'd2 || i2c_data !== exp_word[2]) begin errors++; $display("FAIL ign_next: got index=%0d data=%h expected index=2 data=%h", cfg_index, i2c_data, exp_word[2]); end
    endtask

`ifdef CODEC_CFG_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        do_reset();
        n = 0;
        while (cfg_error !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++; if (cfg_error !== 1'b1) begin errors++; $display("FAIL to_error: got %b expected 1", cfg_error); end
        checks++; if (cfg_index !== 4'd0) begin errors++; $display("FAIL to_index: got %0d expected 0", cfg_index); end
        checks++; if (rise_data.size() != 3) begin errors++; $display("FAIL to_attempts: got %0d expected 3", rise_data.size()); end
        checks++; if (i2c_req !== 1'b0) begin errors++; $display("FAIL to_req: got %b expected 0", i2c_req); end
    endtask
`endif

    initial begin
        test_reset();
        test_full_sequence();
        test_nack_retry();
        test_nack_error();
        test_reset_mid();
        test_ignored();
`ifdef CODEC_CFG_TIMEOUT_EN
        test_timeout();
`endif
        checks++; if (stable_viol != 0) begin errors++; $display("FAIL data_stable: got %0d changes expected 0", stable_viol); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
